serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial add/subtract unit built around a single full-adder cell: two half adders plus an OR gate, with a registered carry. It accepts two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first. It returns the WIDTH-bit result and the carry-out with a done pulse. It is the sequential consumer of the half-adder cell in the Arithmetic library and trades latency for area against the ripple-carry adder.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request strobe; sampled only in IDLE
sub  input  1  0 = A+B+cin; 1 = A-B, computed as A+~B+1; cin ignored
A  input  WIDTH  operand A; captured on the accepted start
B  input  WIDTH  operand B; captured on the accepted start
cin  input  1  carry-in for add; captured on the accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; sum and cout valid
sum  output  WIDTH  result; held until the next accepted start
cout  output  1  final carry; for sub, 1 = no borrow (A >= B unsigned)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled on the rising edge.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal operand shift registers, carry flop and bit counter are all cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on an edge with start=1.
  - RUN -> DONE on the edge that processes bit WIDTH-1.
  - DONE -> IDLE unconditionally on the next edge.
- Accept edge (start=1 in IDLE):
  - Load a_sh <= A.
  - Load b_sh <= sub ? ~B : B.
  - Load carry <= sub ? 1 : cin.
  - Clear the bit counter to 0 and clear the sum shift register.
- Each RUN edge:
  - s = a_sh[0] ^ b_sh[0] ^ carry, formed as HA(a,b) then HA(s1,carry).
  - carry <= (a_sh[0]&b_sh[0]) | (s1&carry).
  - sum shift register <= {s, sum_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1.
  - counter increments by 1.
- Final RUN edge (counter==WIDTH-1): sum <= completed shift value, cout <= final carry, state <= DONE.
- Latency: start accepted at edge k. Bits are processed on edges k+1..k+WIDTH. done=1 during the cycle after edge k+WIDTH and is cleared at edge k+WIDTH+1.
  - Start-to-done = WIDTH+1 edges.
  - Back-to-back throughput = one result per WIDTH+2 cycles.
- Output register visibility: sum and cout change only on the final RUN edge. Intermediate shift values are never visible on sum.
- busy: 1 from the edge after accept through the DONE cycle; 0 in IDLE.
- start while busy (RUN or DONE): ignored. Operands, sum, cout and timing are unaffected, and no request is queued.
- A, B, cin, sub changing after accept: no effect; the values were captured on the accept edge.
- Reset mid-operation: on the next edge with rst_n=0 the block returns to the reset values and the in-flight operation is discarded. No done pulse is produced for it.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the carry out of bit WIDTH-1.

Test Plan:
- Plain add: WIDTH=8, reset, start with A=0x35, B=0x4A, cin=0, sub=0. Required: done high exactly 9 edges after the accept edge, sum=0x7F, cout=0, busy high for 9 cycles.
- Carry wrap: A=0xFF, B=0x01, cin=0 gives sum=0x00, cout=1. Then A=0xFF, B=0xFF, cin=1 gives sum=0xFF, cout=1.
- Subtract: sub=1, A=0x50, B=0x20, cin=1 (ignored) gives sum=0x30, cout=1. Then A=0x20, B=0x50 gives sum=0xD0, cout=0.
- Start and input changes while busy: accept A=0x12, B=0x34. Then assert start with A=0xAA, B=0x55 on the 3rd RUN cycle and again during DONE. Required: single done pulse, sum=0x46, and no second operation begins.
- Reset mid-op: accept A=0x0F, B=0x01, then drive rst_n=0 on the 4th RUN cycle. Required: next cycle shows busy=0, done=0, sum=0x00, cout=0, and no done pulse ever appears. A subsequent start with 0x01+0x02 gives sum=0x03.
- Hold and back-to-back: after a result of 0x7F, sum holds for 20 idle cycles. Start asserted on the first IDLE cycle after DONE is accepted, and the next done follows 9 edges later.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder cell (two half adders plus an OR)
// with a registered carry, one bit per clock, LSB first.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             s1, c1, s, c2, carry_nxt;
   logic [WIDTH-1:0] sh_shift;

   always_comb begin
      s1        = a_q[0] ^ b_q[0];
      c1        = a_q[0] & b_q[0];
      s         = s1 ^ carry_q;
      c2        = s1 & carry_q;
      carry_nxt = c1 | c2;
      // Equivalent to {s, sh_q[WIDTH-1:1]}
      sh_shift  = (sh_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sh_d    = sh_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               a_d     = A;
               b_d     = sub ? ~B : B;
               carry_d = sub ? 1'b1 : cin;
               cnt_d   = '0;
               sh_d    = '0;
            end
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = carry_nxt;
            sh_d    = sh_shift;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               sum_d   = sh_shift;
               cout_d  = carry_nxt;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sh_q    <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sh_q    <= sh_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: expected {cout,sum} queued at accept,
// compared by a monitor whenever done is observed.
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int vectors = 0;
   int miscompares = 0;

   logic [W:0] sb_q[$];
   logic [W-1:0] sum_prev = '0;

   serial_adder #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .sub  (sub),
      .A    (A),
      .B    (B),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .cout (cout)
   );

   always #5 clk = ~clk;

   // Scoreboard consumer; also ensures sum never moves while an operation runs.
   always @(negedge clk) begin
      logic [W:0] exp_v;
      if (rst_n && done) begin
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_done: got done=1 sum=%h, required no done pulse", sum);
         end else begin
            exp_v = sb_q.pop_front();
            if ({cout, sum} !== exp_v) begin
               miscompares++;
               $display("FAIL result: got cout=%b sum=%h, required cout=%b sum=%h",
                        cout, sum, exp_v[W], exp_v[W-1:0]);
            end
         end
      end else if (rst_n && busy) begin
         vectors++;
         if (sum !== sum_prev) begin
            miscompares++;
            $display("FAIL sum_visible: got sum=%h during RUN, required held %h", sum, sum_prev);
         end
      end
      sum_prev = sum;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   // Drives a request at posedge+1 and returns just after the accept edge.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s);
      logic [W:0] bb;
      start = 1'b1; A = a; B = b; cin = c; sub = s;
      @(posedge clk); #1;
      start = 1'b0;
      bb = s ? {1'b0, ~b} : {1'b0, b};
      sb_q.push_back({1'b0, a} + bb + ((s ? 1'b1 : c) ? 9'd1 : 9'd0));
   endtask

   // Edges counted inclusive of the accept edge up to the one raising done.
   task automatic wait_done(output int edges);
      edges = 1;
      while (!done && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, required 0", done); end
      vectors++;
      if (sum !== '0) begin miscompares++; $display("FAIL reset_sum: got %h, required 00", sum); end
      vectors++;
      if (cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b, required 0", cout); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_plain_add;
      int edges, busy_cnt;
      launch(8'h35, 8'h4A, 1'b0, 1'b0);
      edges = 1;
      busy_cnt = busy ? 1 : 0;
      while (!done && edges < 40) begin
         @(posedge clk); #1;
         edges++;
         if (busy) busy_cnt++;
      end
      vectors++;
      if (edges !== 9) begin miscompares++; $display("FAIL add_latency: got %0d edges, required 9", edges); end
      vectors++;
      if (busy_cnt !== 9) begin miscompares++; $display("FAIL add_busy_cycles: got %0d, required 9", busy_cnt); end
      vectors++;
      if (sum !== 8'h7F || cout !== 1'b0) begin
         miscompares++; $display("FAIL add_value: got %b/%h, required 0/7f", cout, sum);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++; $display("FAIL add_done_pulse: got done=%b busy=%b, required 0/0", done, busy);
      end
   endtask

   task automatic test_carry_wrap;
      int edges;
      launch(8'hFF, 8'h01, 1'b0, 1'b0);
      wait_done(edges);
      vectors++;
      if (sum !== 8'h00 || cout !== 1'b1) begin
         miscompares++; $display("FAIL wrap_ff_01: got %b/%h, required 1/00", cout, sum);
      end
      @(posedge clk); #1;
      launch(8'hFF, 8'hFF, 1'b1, 1'b0);
      wait_done(edges);
      vectors++;
      if (sum !== 8'hFF || cout !== 1'b1) begin
         miscompares++; $display("FAIL wrap_ff_ff_c: got %b/%h, required 1/ff", cout, sum);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_subtract;
      int edges;
      launch(8'h50, 8'h20, 1'b1, 1'b1);
      wait_done(edges);
      vectors++;
      if (sum !== 8'h30 || cout !== 1'b1) begin
         miscompares++; $display("FAIL sub_no_borrow: got %b/%h, required 1/30", cout, sum);
      end
      @(posedge clk); #1;
      launch(8'h20, 8'h50, 1'b0, 1'b1);
      wait_done(edges);
      vectors++;
      if (sum !== 8'hD0 || cout !== 1'b0) begin
         miscompares++; $display("FAIL sub_borrow: got %b/%h, required 0/d0", cout, sum);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_busy_ignore;
      int dcnt, dedge;
      launch(8'h12, 8'h34, 1'b0, 1'b0);
      dcnt = 0;
      dedge = 0;
      for (int i = 1; i <= 14; i++) begin
         @(posedge clk); #1;
         if (i == 2) begin start = 1'b1; A = 8'hAA; B = 8'h55; sub = 1'b1; cin = 1'b1; end
         if (i == 3) start = 1'b0;
         if (done) begin
            dcnt++;
            dedge = i;
            vectors++;
            if (sum !== 8'h46 || cout !== 1'b0) begin
               miscompares++; $display("FAIL busy_value: got %b/%h, required 0/46", cout, sum);
            end
            start = 1'b1;
         end else if (dedge != 0 && i == dedge + 1) begin
            start = 1'b0;
         end
      end
      vectors++;
      if (dcnt !== 1) begin miscompares++; $display("FAIL busy_done_count: got %0d, required 1", dcnt); end
      vectors++;
      if (dedge + 1 !== 9) begin miscompares++; $display("FAIL busy_latency: got %0d edges, required 9", dedge + 1); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_no_requeue: got busy=%b, required 0", busy); end
      sub = 1'b0; cin = 1'b0;
   endtask

   task automatic test_reset_midop;
      int edges, dseen;
      launch(8'h0F, 8'h01, 1'b0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      sb_q.delete();
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
         miscompares++;
         $display("FAIL midop_reset: got busy=%b done=%b sum=%h cout=%b, required 0/0/00/0",
                  busy, done, sum, cout);
      end
      rst_n = 1'b1;
      dseen = 0;
      repeat (15) begin @(posedge clk); #1; if (done) dseen++; end
      vectors++;
      if (dseen !== 0) begin miscompares++; $display("FAIL midop_no_done: got %0d pulses, required 0", dseen); end
      launch(8'h01, 8'h02, 1'b0, 1'b0);
      wait_done(edges);
      vectors++;
      if (sum !== 8'h03) begin miscompares++; $display("FAIL midop_after: got %h, required 03", sum); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int edges, bad;
      launch(8'h35, 8'h4A, 1'b0, 1'b0);
      wait_done(edges);
      @(posedge clk); #1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (sum !== 8'h7F || busy !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      vectors++;
      if (bad !== 0) begin miscompares++; $display("FAIL hold: got %0d bad idle cycles, required 0", bad); end
      launch(8'h03, 8'h04, 1'b0, 1'b0);
      wait_done(edges);
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got busy=%b, required 0", busy); end
      launch(8'h10, 8'h20, 1'b0, 1'b0);
      wait_done(edges);
      vectors++;
      if (edges !== 9) begin miscompares++; $display("FAIL b2b_latency: got %0d edges, required 9", edges); end
      vectors++;
      if (sum !== 8'h30) begin miscompares++; $display("FAIL b2b_value: got %h, required 30", sum); end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      int edges;
      for (int n = 0; n < 16; n++) begin
         launch(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
         wait_done(edges);
         vectors++;
         if (edges !== 9) begin miscompares++; $display("FAIL rand_latency: got %0d edges, required 9", edges); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset;
      test_plain_add;
      test_carry_wrap;
      test_subtract;
      test_busy_ignore;
      test_reset_midop;
      test_back_to_back;
      test_random;
      repeat (2) @(posedge clk);
      vectors++;
      if (sb_q.size() !== 0) begin
         miscompares++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
